// File: rtl/pipelined_csa_addsub_if.sv
// rtl/pipelined_csa_addsub_if.sv - operand and result stream bundle for pipelined_csa_addsub
interface pipelined_csa_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_c;
    logic             out_v;
    logic             out_z;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, in_sat, out_ready,
        input  in_ready, out_valid, out_y, out_c, out_v, out_z
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, in_sat, out_ready,
        output in_ready, out_valid, out_y, out_c, out_v, out_z
    );
endinterface

// File: rtl/pipelined_csa_addsub.sv
// rtl/pipelined_csa_addsub.sv - pipelined carry-select add/sub with saturation, flags and stream handshake
module pipelined_csa_addsub #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int GRP   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_csa_addsub_if.slave bus
);
    localparam int NBLK   = WIDTH / BLK;
    localparam int STAGES = NBLK / GRP;
    localparam int SW     = GRP * BLK;

    if ((WIDTH % BLK) != 0 || (NBLK % GRP) != 0 || STAGES < 1) begin : g_param_check
        $error("pipelined_csa_addsub: WIDTH must split into BLK-bit blocks and the blocks into GRP-block stages");
    end

    logic             adv;
    logic             out_valid_q;
    logic             out_c_q;
    logic             out_v_q;
    logic             out_z_q;
    logic [WIDTH-1:0] out_y_q;

    // single global stall: nothing moves while a result waits for the consumer
    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_v     = out_v_q;
    assign bus.out_z     = out_z_q;

    for (genvar j = 0; j < STAGES; j++) begin : stg
        // this stage resolves bits [HI-1:LO]; only operand bits from LO upward still matter here
        localparam int LO = j * SW;
        localparam int HI = LO + SW;

        logic              vld_i;
        logic              c_i;
        logic              sub_i;
        logic              sat_i;
        logic              c_o;
        logic [WIDTH-1:LO] a_i;
        logic [WIDTH-1:LO] x_i;
        logic [SW-1:0]     ysl;
        logic [HI-1:0]     y_o;
        logic [BLK:0]      s0;
        logic [BLK:0]      s1;
        logic              cc;

        if (j == 0) begin : g_src
            assign vld_i = bus.in_valid;
            assign a_i   = bus.in_a;
            assign x_i   = bus.in_b ^ {WIDTH{bus.in_sub}};
            assign c_i   = bus.in_cin ^ bus.in_sub;
            assign sub_i = bus.in_sub;
            assign sat_i = bus.in_sat;
            assign y_o   = ysl;
        end else begin : g_src
            assign vld_i = stg[j-1].g_mid.vld_q;
            assign a_i   = stg[j-1].g_mid.a_q;
            assign x_i   = stg[j-1].g_mid.x_q;
            assign c_i   = stg[j-1].g_mid.c_q;
            assign sub_i = stg[j-1].g_mid.sub_q;
            assign sat_i = stg[j-1].g_mid.sat_q;
            assign y_o   = {ysl, stg[j-1].g_mid.y_q};
        end

        // each block precomputes sums for both carry values; the carry arriving at the block picks one
        always_comb begin
            cc  = c_i;
            ysl = '0;
            s0  = '0;
            s1  = '0;
            for (int g = 0; g < GRP; g++) begin
                s0 = {1'b0, a_i[LO + g*BLK +: BLK]} + {1'b0, x_i[LO + g*BLK +: BLK]};
                s1 = {1'b0, a_i[LO + g*BLK +: BLK]} + {1'b0, x_i[LO + g*BLK +: BLK]} + (BLK+1)'(1);
                ysl[g*BLK +: BLK] = cc ? s1[BLK-1:0] : s0[BLK-1:0];
                cc = cc ? s1[BLK] : s0[BLK];
            end
            c_o = cc;
        end

        if (j < STAGES - 1) begin : g_mid
            logic              vld_q;
            logic              c_q;
            logic              sub_q;
            logic              sat_q;
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] x_q;
            logic [HI-1:0]     y_q;

            // stage valid bit; bubbles are kept, so it follows the stall like the data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                end else if (adv) begin
                    vld_q <= vld_i;
                end
            end

            // payload: resolved low slices, pending high operand slices, carry and sidebands
            always_ff @(posedge clk) begin
                if (adv && vld_i) begin
                    a_q   <= a_i[WIDTH-1:HI];
                    x_q   <= x_i[WIDTH-1:HI];
                    y_q   <= y_o;
                    c_q   <= c_o;
                    sub_q <= sub_i;
                    sat_q <= sat_i;
                end
            end
        end else begin : g_last
            logic             ovf;
            logic [WIDTH-1:0] y_fin;

            // signed overflow from operand/result signs, then clamp toward the sign of A
            always_comb begin
                ovf   = (a_i[WIDTH-1] == x_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
                y_fin = y_o;
                if (sat_i && ovf) begin
                    y_fin = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end

            // registered result; flags are captured alongside so they stay aligned under stall
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_y_q     <= '0;
                    out_c_q     <= 1'b0;
                    out_v_q     <= 1'b0;
                    out_z_q     <= 1'b0;
                end else if (adv) begin
                    out_valid_q <= vld_i;
                    if (vld_i) begin
                        out_y_q <= y_fin;
                        out_c_q <= c_o ^ sub_i;
                        out_v_q <= ovf;
                        out_z_q <= (y_fin == '0);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_csa_addsub.sv
// tb/tb_pipelined_csa_addsub.sv - self-checking bench for pipelined_csa_addsub
module tb_pipelined_csa_addsub;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic        sat;
        logic [31:0] y;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    typedef struct {
        logic [63:0] y;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    localparam int NV  = 12;
    localparam int NSW = 40;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic sw_rst_n = 1'b0;
    int   errors   = 0;
    int   checks   = 0;
    int   sw_fin   = 0;
    vec_t vt [NV];

    always #5 clk = ~clk;

    pipelined_csa_addsub_if #(.WIDTH(32)) bus ();
    pipelined_csa_addsub #(.WIDTH(32), .BLK(4), .GRP(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: exact integer arithmetic on unsigned and signed views of the operands
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input logic cin, input logic sat);
        res_t r;
        logic signed [67:0] p, ua, ub, sa, sb, ur, sr, maxv, minv;
        logic [63:0] mask;
        p    = 68'sd1;
        p    = p <<< w;
        mask = 64'(p - 68'sd1);
        ua   = 68'(a);
        ub   = 68'(b);
        sa   = a[w-1] ? ua - p : ua;
        sb   = b[w-1] ? ub - p : ub;
        if (sub) begin
            ur = ua - ub - 68'(cin);
            sr = sa - sb - 68'(cin);
        end else begin
            ur = ua + ub + 68'(cin);
            sr = sa + sb + 68'(cin);
        end
        maxv = (p >>> 1) - 68'sd1;
        minv = -(p >>> 1);
        r.y  = 64'(ur) & mask;
        r.c  = sub ? (ur < 68'sd0) : (ur >= p);
        r.v  = (sr > maxv) || (sr < minv);
        if (sat && r.v) r.y = (sr > maxv) ? 64'(maxv) : (64'(minv) & mask);
        r.z  = (r.y == 64'd0);
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic cin, input logic sat);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_sub = sub;
        bus.in_cin = cin;
        bus.in_sat = sat;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        int n;
        n = 0;
        drive(t.a, t.b, t.sub, t.cin, t.sat);
        bus.in_valid = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) bus.in_valid = 1'b0;
        end while (!bus.out_valid && n < 20);
        chk($sformatf("vec%0d_valid", idx), 72'(bus.out_valid), 72'(1));
        chk($sformatf("vec%0d_latency", idx), 72'(n), 72'(4));
        chk($sformatf("vec%0d_y", idx), 72'(bus.out_y), 72'(t.y));
        chk($sformatf("vec%0d_cvz", idx), 72'({bus.out_c, bus.out_v, bus.out_z}), 72'({t.c, t.v, t.z}));
        @(posedge clk); #1;
    endtask

    // reduced-width and single-stage configurations, free-running with the consumer always ready
    for (genvar i = 0; i < 3; i++) begin : sw
        localparam int W   = (i == 0) ? 16 : (i == 1) ? 24 : 64;
        localparam int BL  = (i == 1) ? 8 : 4;
        localparam int GR  = (i == 0) ? 1 : (i == 1) ? 3 : 4;
        localparam int LAT = W / BL / GR;

        pipelined_csa_addsub_if #(.WIDTH(W)) sif ();
        pipelined_csa_addsub #(.WIDTH(W), .BLK(BL), .GRP(GR)) dut (.clk(clk), .rst_n(sw_rst_n), .bus(sif));

        res_t q [$];
        time  t_acc;

        initial begin : drv
            logic [63:0] a, b, m;
            logic        s, ci, st;
            m = (64'd1 << W) - 64'd1;
            sif.in_valid = 1'b0;
            sif.in_a = '0; sif.in_b = '0; sif.in_sub = 1'b0; sif.in_cin = 1'b0; sif.in_sat = 1'b0;
            sif.out_ready = 1'b1;
            @(posedge sw_rst_n);
            @(posedge clk); #1;
            for (int n = 0; n < NSW; n++) begin
                if (n < 2) begin
                    a = 64'd1 << (W - 1); b = a; s = 1'b0; ci = 1'b0; st = (n == 1);
                end else begin
                    a  = {$urandom, $urandom} & m;
                    b  = {$urandom, $urandom} & m;
                    s  = 1'($urandom_range(0, 1));
                    ci = 1'($urandom_range(0, 1));
                    st = 1'($urandom_range(0, 1));
                end
                sif.in_a = a[W-1:0]; sif.in_b = b[W-1:0];
                sif.in_sub = s; sif.in_cin = ci; sif.in_sat = st;
                sif.in_valid = 1'b1;
                q.push_back(model(W, a, b, s, ci, st));
                if (n == 0) t_acc = $time + 9;
                @(posedge clk); #1;
            end
            sif.in_valid = 1'b0;
        end

        initial begin : mon
            int   got, cyc;
            res_t e;
            got = 0; cyc = 0;
            @(posedge sw_rst_n);
            while (got < NSW && cyc < 400) begin
                @(negedge clk);
                cyc++;
                if (sif.out_valid) begin
                    if (got == 0) chk($sformatf("sw%0d_latency", i), 72'(($time - t_acc - 5) / 10 + 1), 72'(LAT));
                    if (got < 2) chk($sformatf("sw%0d_minmin_v", i), 72'(sif.out_v), 72'(1));
                    if (q.size() == 0) begin
                        chk($sformatf("sw%0d_extra", i), 72'(1), 72'(0));
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sw%0d_res%0d", i, got),
                            {5'd0, 64'(sif.out_y), sif.out_c, sif.out_v, sif.out_z},
                            {5'd0, e.y, e.c, e.v, e.z});
                    end
                    got++;
                end
            end
            chk($sformatf("sw%0d_count", i), 72'(got), 72'(NSW));
            sw_fin++;
        end
    end

    initial begin
        res_t sq [$];
        int   got, stalls, seen, w;
        logic [34:0] hold;
        logic        held;

        vt[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vt[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{32'h00000003, 32'h00000003, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[10] = '{32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vt[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 72'({bus.out_valid, bus.out_y, bus.out_c, bus.out_v, bus.out_z}), 72'(0));
        rst_n = 1'b1;
        sw_rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 72'(bus.in_ready), 72'(1));

        for (int i = 0; i < NV; i++) run_vec(vt[i], i);

        // stream of 10 random ops with a 3-cycle consumer stall in the middle
        got = 0; stalls = 0; held = 1'b0; hold = '0;
        fork
            begin : stream_drv
                logic [31:0] ra, rb;
                logic        rs, rc, rt;
                int          wt;
                for (int k = 0; k < 10; k++) begin
                    ra = $urandom; rb = $urandom;
                    rs = 1'($urandom_range(0, 1));
                    rc = 1'($urandom_range(0, 1));
                    rt = 1'($urandom_range(0, 1));
                    drive(ra, rb, rs, rc, rt);
                    bus.in_valid = 1'b1;
                    wt = 0;
                    @(negedge clk);
                    while (!bus.in_ready && wt < 50) begin
                        @(negedge clk);
                        wt++;
                    end
                    sq.push_back(model(32, 64'(ra), 64'(rb), rs, rc, rt));
                    @(posedge clk); #1;
                end
                bus.in_valid = 1'b0;
            end
            begin : stream_stall
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
            begin : stream_mon
                int   cyc;
                res_t e;
                cyc = 0;
                while (got < 10 && cyc < 300) begin
                    @(negedge clk);
                    cyc++;
                    if (held) chk("stall_hold", 72'({bus.out_valid, bus.out_y, bus.out_c, bus.out_v, bus.out_z}),
                                  72'({1'b1, hold}));
                    held = 1'b0;
                    if (bus.out_valid && !bus.out_ready) begin
                        chk("stall_in_ready", 72'(bus.in_ready), 72'(0));
                        hold = {bus.out_y, bus.out_c, bus.out_v, bus.out_z};
                        held = 1'b1;
                        stalls++;
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        if (sq.size() == 0) begin
                            chk("stream_extra", 72'(1), 72'(0));
                        end else begin
                            e = sq.pop_front();
                            chk($sformatf("stream%0d", got),
                                72'({bus.out_y, bus.out_c, bus.out_v, bus.out_z}),
                                72'({e.y[31:0], e.c, e.v, e.z}));
                        end
                        got++;
                    end
                end
            end
        join
        chk("stream_count", 72'(got), 72'(10));
        chk("stream_stalls", 72'(stalls), 72'(3));

        // reset with three transactions in flight, the oldest already presented
        for (int k = 0; k < 3; k++) begin
            drive(32'd5 + 32'(k), 32'd3, 1'b0, 1'b0, 1'b0);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_pre_valid", 72'({bus.out_valid, bus.out_y}), 72'({1'b1, 32'd8}));
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 72'({bus.out_valid, bus.out_y, bus.out_c, bus.out_v, bus.out_z}), 72'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("midrst_no_valid", 72'(seen), 72'(0));
        chk("midrst_in_ready", 72'(bus.in_ready), 72'(1));
        @(posedge clk); #1;
        run_vec(vt[6], 99);

        w = 0;
        while (sw_fin < 3 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        chk("sweep_done", 72'(sw_fin), 72'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_csa_addsub.md
# pipelined_csa_addsub

Parametrised, pipelined carry-select adder/subtractor, the successor to the fixed 16-bit combinational carry-select add/sub. It splits a WIDTH-bit operation into BLK-bit carry-select blocks and resolves GRP blocks per pipeline stage. It adds carry/borrow-in, signed saturation, full status flags and a valid/ready stream interface. It sits in the datapath between operand registers and the result writeback stream.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of BLK.
- BLK, 4: bits per carry-select block; each block computes sums for carry 0 and 1.
- GRP, 2: blocks resolved per pipeline stage; NBLK = WIDTH/BLK must be a multiple of GRP. A violation fails elaboration.
- Derived: NBLK = WIDTH/BLK, STAGES = NBLK/GRP.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0: add, 1: subtract.
- in_cin  in  1  carry-in (add) / borrow-in (sub).
- in_sat  in  1  1: saturate signed result on overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_y  out  WIDTH  result.
- out_c  out  1  carry-out (add) / borrow-out (sub).
- out_v  out  1  signed overflow, pre-saturation.
- out_z  out  1  out_y == 0, post-saturation.

## Operation
- X = in_b XOR {WIDTH{in_sub}}; block-0 carry-in c0 = in_cin XOR in_sub. Subtract therefore computes A − B − borrow.
- Each block k computes s0_k = A_k+X_k+0 and s1_k = A_k+X_k+1 with carries co0_k/co1_k. Selection: Y_k = c_k ? s1_k : s0_k; c_{k+1} = c_k ? co1_k : co0_k.
- Stage j (0..STAGES-1) resolves blocks j·GRP … j·GRP+GRP−1 combinationally from the registered carry of stage j−1 (stage 0 uses c0). It registers its result slices and outgoing carry.
- Skew: operand slices for later stages are delayed in registers until their stage. Result slices from earlier stages are delayed so all slices of one transaction emerge together. The sub/sat/A-msb/X-msb sidebands travel with the transaction.
- Final stage: raw carry cN. out_c = cN XOR sub. V = (A_msb == X_msb) && (Y_msb != A_msb).
- Saturation: if sat && V, out_y = A_msb ? {1,0…0} : {0,1…1}; otherwise raw Y. out_v reports V regardless of sat. out_z is evaluated on the final out_y.
- in_sat applies to both add and sub. in_cin is honoured in all modes.

## Timing
- Latency: STAGES cycles from the in_valid && in_ready edge to out_valid (defaults: 4).
- Throughput: one transaction per cycle when unstalled.
- Global stall: adv = !out_valid || out_ready; in_ready = adv, combinational. When adv=0, every pipeline register, including valid bits, holds.
- Bubbles are not collapsed. A stage holding invalid data still stalls behind a blocked output.
- Outputs are registered, and out_y/out_c/out_v/out_z are stable while out_valid && !out_ready.
- Data registers update only when adv and the incoming stage valid is 1. Payload under out_valid=0 is don't-care for checks.
- Reset: every valid bit = 0, out_y = 0, out_c = out_v = out_z = 0. in_ready = 1 once rst_n deasserts.
- Reset mid-operation: all in-flight transactions are discarded, and none emerge after release.
- Wrap-around is modular at WIDTH bits unless saturated. The carry chain spans all NBLK blocks with no loss at stage boundaries.

## Test plan
- Defaults, add: A=0x7FFFFFFF, B=1, sat=0, cin=0 -> Y=0x80000000, V=1, C=0, Z=0. The same with sat=1 -> Y=0x7FFFFFFF, V=1. Both arrive 4 cycles after acceptance.
- Subtract: A=0, B=1, cin=0 -> Y=0xFFFFFFFF, C=1 (borrow), V=0. A=0x80000000, B=1, sat=1 -> Y=0x80000000, V=1.
- Full carry ripple across all stages: A=0xFFFFFFFF, B=0, cin=1, add -> Y=0, C=1, Z=1, V=0. Repeat with A=0x0000FFFF and B=1 to cross the stage-1 to stage-2 boundary.
- Streaming with backpressure: 10 back-to-back random ops. Hold out_ready=0 for 3 cycles mid-stream -> in_ready low during the stall, outputs held stable, and all results in order, matching the reference model, with none lost or duplicated.
- Reset mid-flight: accept 3 ops, assert rst_n=0 for 1 cycle -> all outputs 0 immediately, and no out_valid until new ops are issued.
- Parameter sweep: WIDTH=16/BLK=4/GRP=1 (latency 4), WIDTH=24/BLK=8/GRP=3 (latency 1), and WIDTH=64/BLK=4/GRP=4 (latency 4). Run random add/sub/sat against the model, and include the cases A=0x80000000…, B=0x80000000… add -> V=1.
